seven_segment_scanner: RTL and testbench

Time-multiplexed scan controller that shares one combinational seven-segment decoder across `DIGITS` common-anode/cathode digit positions. It holds a frame of 4-bit digit codes, presents one code at a time to the shared decoder's A..D inputs, and enables the matching digit driver. A blanking interval precedes each digit to suppress ghosting. New display data is double-buffered and swapped only at frame boundaries, so a frame never shows mixed old and new digits.

---
 rtl/seven_segment_scanner_if.sv | 24 ++
 rtl/seven_segment_scanner.sv | 144 ++++++++++++++
 tb/tb_seven_segment_scanner.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_scanner_if.sv
// Host-side signal bundle for the seven-segment scanner: display data in,
// shared-decoder code and digit enables out.
interface seven_segment_scanner_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  en;
  logic                  load;
  logic [4*DIGITS-1:0]   data;
  logic                  lz_en;
  logic [3:0]            code;
  logic [DIGITS-1:0]     digit_en;
  logic                  frame_done;
  logic                  pending;

  modport master (
    output en, load, data, lz_en,
    input  code, digit_en, frame_done, pending
  );

  modport slave (
    input  en, load, data, lz_en,
    output code, digit_en, frame_done, pending
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment scan controller with per-digit blanking
// interval, leading-zero suppression and frame-synchronous double buffering.
module seven_segment_scanner #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DWELL  = 1000,
  parameter int unsigned BLANK  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seven_segment_scanner_if.slave bus
);
  localparam int unsigned DW   = 4 * DIGITS;
  localparam int unsigned IW   = $clog2(DIGITS);
  localparam int unsigned MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0]     DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0]     BLANK_LAST = CW'(BLANK - 1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] ONE_HOT0   = DIGITS'(1);

  typedef enum logic [1:0] {IDLE, BLANKING, SHOW} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]       shadow_q, shadow_d;
  logic [DW-1:0]       active_q, active_d;
  logic                pending_q, pending_d;
  logic                frame_done_q, frame_done_d;
  logic [3:0]          code_q, code_d;
  logic [DIGITS-1:0]   digit_en_q, digit_en_d;
  logic [DIGITS-1:0]   blank_mask;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.load) active_d = bus.data;
        if (bus.en) begin
          state_d = BLANKING;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      BLANKING, SHOW: begin
        if (!bus.en) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
          if (pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
          end
          // Entering IDLE: a coincident load behaves as an IDLE load.
          if (bus.load) begin
            active_d  = bus.data;
            pending_d = 1'b0;
          end
        end else begin
          if (bus.load) begin
            shadow_d  = bus.data;
            pending_d = 1'b1;
          end
          if (state_q == BLANKING) begin
            if (cnt_q == BLANK_LAST) begin
              state_d = SHOW;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (cnt_q == DWELL_LAST) begin
            state_d = BLANKING;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d        = '0;
              frame_done_d = 1'b1;
              // Frame boundary: a load here bypasses the shadow entirely.
              if (bus.load) begin
                shadow_d  = shadow_q;
                active_d  = bus.data;
                pending_d = 1'b0;
              end else if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
              end
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from next-state so they register alongside it.
  always_comb begin
    blank_mask = '0;
    for (int unsigned i = 1; i < DIGITS; i++) begin
      blank_mask[i] = bus.lz_en && ((active_d >> (4 * i)) == '0);
    end
    code_d     = (state_d == IDLE) ? 4'h0 : active_d[{idx_d, 2'b00} +: 4];
    digit_en_d = (state_d == SHOW && !blank_mask[idx_d]) ? (ONE_HOT0 << idx_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      code_q       <= '0;
      digit_en_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      code_q       <= code_d;
      digit_en_q   <= digit_en_d;
    end
  end

  assign bus.code       = code_q;
  assign bus.digit_en   = digit_en_q;
  assign bus.frame_done = frame_done_q;
  assign bus.pending    = pending_q;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with DIGITS=4, DWELL=4, BLANK=2
// (slot = 6 cycles, frame = 24 cycles).
module tb_seven_segment_scanner;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   tcnt;

  seven_segment_scanner_if #(.DIGITS(4)) bus ();

  seven_segment_scanner #(
    .DIGITS(4),
    .DWELL (4),
    .BLANK (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tcnt++;
  endtask

  task automatic wait_to(input int target);
    while (tcnt < target) step();
  endtask

  initial begin
    logic [3:0] exp_en;
    logic [3:0] nib;
    n_cmp = 0;
    n_bad = 0;
    tcnt  = 0;
    rst_n = 1'b0;
    bus.en = 1'b0; bus.load = 1'b0; bus.data = '0; bus.lz_en = 1'b0;
    repeat (3) step();
    chk("rst_code", bus.code, 0);
    chk("rst_en", bus.digit_en, 0);
    chk("rst_fd", bus.frame_done, 0);
    chk("rst_pend", bus.pending, 0);
    rst_n = 1'b1;
    step();

    // IDLE load goes straight to active, code stays 0
    bus.data = 16'h4321; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    chk("idle_active", dut.active_q, 32'h4321);
    chk("idle_code", bus.code, 0);
    chk("idle_pend", bus.pending, 0);

    // Frame 1: t=0 is the first BLANKING cycle
    bus.en = 1'b1;
    step();
    tcnt = 0;
    for (int c = 0; c < 24; c++) begin
      wait_to(c);
      exp_en = ((c % 6) >= 2) ? (4'b0001 << (c / 6)) : 4'b0000;
      chk("f1_en", bus.digit_en, exp_en);
      chk("f1_code", bus.code, c / 6 + 1);
      chk("f1_fd", bus.frame_done, 0);
    end
    wait_to(24);
    chk("f1_end_fd", bus.frame_done, 1);
    chk("f1_end_en", bus.digit_en, 0);
    chk("f1_end_code", bus.code, 1);

    // Double buffer: load mid-frame during digit 1 show
    wait_to(32);
    bus.data = 16'hABCD; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    chk("db_pend", bus.pending, 1);
    chk("db_en1", bus.digit_en, 4'b0010);
    chk("db_code1", bus.code, 2);
    wait_to(38);
    chk("db_code2", bus.code, 3);
    chk("db_en2", bus.digit_en, 4'b0100);
    wait_to(44);
    chk("db_code3", bus.code, 4);
    chk("db_en3", bus.digit_en, 4'b1000);
    wait_to(47);
    chk("db_pend_late", bus.pending, 1);
    chk("db_fd_late", bus.frame_done, 0);
    wait_to(48);
    chk("db_fd", bus.frame_done, 1);
    chk("db_pend_clr", bus.pending, 0);
    chk("db_active", dut.active_q, 32'hABCD);
    chk("db_code_new", bus.code, 4'hD);
    chk("db_en_blank", bus.digit_en, 0);
    wait_to(50);
    chk("db_en_d0", bus.digit_en, 4'b0001);
    chk("db_code_d0", bus.code, 4'hD);

    // Load in the last SHOW cycle of the frame bypasses the shadow
    wait_to(71);
    chk("fe_pre_en", bus.digit_en, 4'b1000);
    chk("fe_pre_code", bus.code, 4'hA);
    bus.data = 16'h0F0F; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    chk("fe_fd", bus.frame_done, 1);
    chk("fe_pend", bus.pending, 0);
    chk("fe_code", bus.code, 4'hF);
    for (int s = 0; s < 4; s++) begin
      wait_to(74 + 6 * s);
      nib = (s % 2 == 0) ? 4'hF : 4'h0;
      chk("fe_code_s", bus.code, nib);
      chk("fe_en_s", bus.digit_en, 4'b0001 << s);
      chk("fe_pend_s", bus.pending, 0);
    end

    // Pending load, then en dropped during digit 2 show
    wait_to(99);
    bus.data = 16'h0005; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    chk("dr_pend", bus.pending, 1);
    wait_to(110);
    chk("dr_pre_en", bus.digit_en, 4'b0100);
    chk("dr_pre_code", bus.code, 4'hF);
    bus.en = 1'b0;
    step();
    chk("dr_en", bus.digit_en, 0);
    chk("dr_idx", dut.idx_q, 0);
    chk("dr_fd", bus.frame_done, 0);
    chk("dr_code", bus.code, 0);
    chk("dr_pend_clr", bus.pending, 0);
    chk("dr_active", dut.active_q, 32'h0005);

    // Restart with leading-zero blanking on active=0x0005
    bus.lz_en = 1'b1;
    bus.en = 1'b1;
    step();
    tcnt = 0;
    chk("lz_start_code", bus.code, 5);
    for (int c = 0; c < 24; c++) begin
      wait_to(c);
      exp_en = (c >= 2 && c < 6) ? 4'b0001 : 4'b0000;
      chk("lz_en", bus.digit_en, exp_en);
      chk("lz_fd", bus.frame_done, 0);
    end
    wait_to(24);
    chk("lz_frame_fd", bus.frame_done, 1);

    // Active all zero: digit 0 still shown
    bus.en = 1'b0;
    step();
    bus.data = 16'h0000; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    bus.en = 1'b1;
    step();
    tcnt = 0;
    wait_to(2);
    chk("z_en", bus.digit_en, 4'b0001);
    chk("z_code", bus.code, 0);
    wait_to(3);
    bus.data = 16'h1111; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    chk("ar_pend_pre", bus.pending, 1);
    chk("ar_en_pre", bus.digit_en, 4'b0001);

    // Asynchronous reset between clock edges
    #3 rst_n = 1'b0;
    #1;
    chk("ar_en", bus.digit_en, 0);
    chk("ar_code", bus.code, 0);
    chk("ar_pend", bus.pending, 0);
    #2 rst_n = 1'b1;
    step();
    tcnt = 0;
    chk("ar_shadow", dut.shadow_q, 0);
    chk("ar_blank_en", bus.digit_en, 0);
    wait_to(2);
    chk("ar_show_en", bus.digit_en, 4'b0001);
    chk("ar_show_code", bus.code, 0);
    chk("ar_pend_after", bus.pending, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
